// File: rtl/mul_div_unit_pkg.sv
// Shared constants for the multiply/divide unit: SPECIAL opcode, HI/LO-class
// funct codes, and instruction decode helpers.
package mul_div_unit_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  // Any instruction that reads or writes HI/LO (these stall while busy).
  function automatic logic is_hilo(input logic [31:0] ins);
    logic [5:0] f;
    f = ins[5:0];
    return (ins[31:26] == OP_SPECIAL) &&
           (f == F_MFHI || f == F_MTHI || f == F_MFLO || f == F_MTLO ||
            f == F_MULT || f == F_MULTU || f == F_DIV || f == F_DIVU);
  endfunction

  // Iterative operations that start the unit.
  function automatic logic is_muldiv(input logic [31:0] ins);
    logic [5:0] f;
    f = ins[5:0];
    return (ins[31:26] == OP_SPECIAL) &&
           (f == F_MULT || f == F_MULTU || f == F_DIV || f == F_DIVU);
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Execute-stage <-> multiply/divide unit bus.
//   master (execute stage): drives En, Flush, Ins, Rdata1, Rdata2
//   slave  (mul_div_unit):  drives HiLo_data, Busy, Stall, Done
interface mul_div_unit_if;
  logic        En;
  logic        Flush;
  logic [31:0] Ins;
  logic [31:0] Rdata1;
  logic [31:0] Rdata2;
  logic [31:0] HiLo_data;
  logic        Busy;
  logic        Stall;
  logic        Done;

  modport master (output En, Flush, Ins, Rdata1, Rdata2,
                  input  HiLo_data, Busy, Stall, Done);
  modport slave  (input  En, Flush, Ins, Rdata1, Rdata2,
                  output HiLo_data, Busy, Stall, Done);
endinterface

// File: rtl/mul_div_unit_mdu_datapath.sv
// mdu_datapath: 64-bit accumulator with one shift-add (multiply) or one
// restoring-division step per `step`, plus combinational sign fix.
//   clk, rst_n        clock, async active-low reset
//   load              latch operands (absolute values for signed ops)
//   step              advance one iteration
//   is_div, is_signed operation kind, sampled on load
//   rs, rt            raw operands
//   res_hi, res_lo    sign-corrected result, valid after 32 steps
module mdu_datapath (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  input  logic        is_div,
  input  logic        is_signed,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  // Multiply: acc = {partial product, remaining multiplier bits}, opnd = multiplicand.
  // Divide:   acc = {partial remainder, dividend/quotient bits},  opnd = divisor.
  logic [63:0] acc;
  logic [31:0] opnd;
  logic        div_op, qsign, rsign, divz;

  logic [31:0] abs_rs, abs_rt;
  logic [32:0] mul_sum, pr, pr_sub;
  logic        ge;
  logic [63:0] prod;
  logic        unused_borrow;

  assign abs_rs = (is_signed && rs[31]) ? -rs : rs;
  assign abs_rt = (is_signed && rt[31]) ? -rt : rt;

  assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);

  // Shift the next dividend bit into the 33-bit partial remainder and try the subtract.
  assign pr            = {acc[63:32], acc[31]};
  assign ge            = pr >= {1'b0, opnd};
  assign pr_sub        = pr - {1'b0, opnd};
  assign unused_borrow = pr_sub[32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      opnd   <= '0;
      div_op <= 1'b0;
      qsign  <= 1'b0;
      rsign  <= 1'b0;
      divz   <= 1'b0;
    end else if (load) begin
      acc    <= {32'd0, is_div ? abs_rs : abs_rt};
      opnd   <= is_div ? abs_rt : abs_rs;
      div_op <= is_div;
      qsign  <= is_signed & (rs[31] ^ rt[31]);
      rsign  <= is_signed & rs[31];
      divz   <= is_div & (rt == 32'd0);
    end else if (step) begin
      if (div_op)
        acc <= ge ? {pr_sub[31:0], acc[30:0], 1'b1} : {pr[31:0], acc[30:0], 1'b0};
      else
        acc <= {mul_sum, acc[31:1]};
    end
  end

  // Divide by zero naturally leaves |rs| as remainder and all-ones quotient;
  // re-signing the remainder with rsign recovers the original rs, and the
  // quotient is forced to all-ones so the signed case matches the unsigned one.
  assign prod   = qsign ? -acc : acc;
  assign res_hi = div_op ? (rsign ? -acc[63:32] : acc[63:32]) : prod[63:32];
  assign res_lo = div_op ? (divz ? 32'hFFFF_FFFF : (qsign ? -acc[31:0] : acc[31:0]))
                         : prod[31:0];

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle MULT/MULTU/DIV/DIVU with HI/LO registers,
// MTHI/MTLO writes and MFHI/MFLO read mux for the execute result path.
//   CLK   system clock
//   RST   async active-low reset
//   bus   mul_div_unit_if.slave (En, Flush, Ins, Rdata1, Rdata2 in;
//         HiLo_data, Busy, Stall, Done out)
// Busy spans 32 iteration cycles plus one FIX cycle; Done pulses the cycle
// after FIX, when the new HI/LO are already readable.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int ITER = 32
) (
  input  logic           CLK,
  input  logic           RST,
  mul_div_unit_if.slave  bus
);

  localparam int             CW   = $clog2(ITER);
  localparam logic [CW-1:0]  LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t        state, nstate;
  logic [CW-1:0] cnt;
  logic [31:0]   hi, lo, res_hi, res_lo;
  logic          done_q, load, step, wr_res;
  logic [5:0]    funct;
  logic          special, busy, start, mt_ok, is_div, is_signed;
  logic          unused_ins;

  assign funct      = bus.Ins[5:0];
  assign special    = bus.Ins[31:26] == OP_SPECIAL;
  assign unused_ins = ^bus.Ins[25:6];
  assign busy       = state != S_IDLE;
  assign start      = bus.En & ~bus.Flush & ~busy & is_muldiv(bus.Ins);
  assign mt_ok      = bus.En & ~bus.Flush & ~busy & special;
  assign is_div     = (funct == F_DIV)  | (funct == F_DIVU);
  assign is_signed  = (funct == F_MULT) | (funct == F_DIV);

  assign bus.Busy      = busy;
  assign bus.Stall     = bus.En & busy & is_hilo(bus.Ins);
  assign bus.Done      = done_q;
  assign bus.HiLo_data = !special          ? 32'd0 :
                         (funct == F_MFHI) ? hi    :
                         (funct == F_MFLO) ? lo    : 32'd0;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= nstate;
  end

  always_comb begin
    nstate = state;
    load   = 1'b0;
    step   = 1'b0;
    wr_res = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        load   = 1'b1;
        nstate = is_div ? S_DIV : S_MUL;
      end
      S_MUL, S_DIV: begin
        if (bus.Flush) nstate = S_IDLE;
        else begin
          step = 1'b1;
          if (cnt == LAST) nstate = S_FIX;
        end
      end
      S_FIX: begin
        nstate = S_IDLE;
        wr_res = ~bus.Flush;
      end
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt    <= '0;
      done_q <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done_q <= wr_res;
      if (load)      cnt <= '0;
      else if (step) cnt <= cnt + 1'b1;

      if (wr_res)                        hi <= res_hi;
      else if (mt_ok && funct == F_MTHI) hi <= bus.Rdata1;

      if (wr_res)                        lo <= res_lo;
      else if (mt_ok && funct == F_MTLO) lo <= bus.Rdata1;
    end
  end

  mdu_datapath u_dp (
    .clk       (CLK),
    .rst_n     (RST),
    .load      (load),
    .step      (step),
    .is_div    (is_div),
    .is_signed (is_signed),
    .rs        (bus.Rdata1),
    .rt        (bus.Rdata2),
    .res_hi    (res_hi),
    .res_lo    (res_lo)
  );

endmodule
